// File: rtl/exp_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : exp_share_arbiter
// Desc     : Shares one BF16 exp approximation unit among NREQ requesters.
//            Round-robin grant, tag pipeline matching the unit latency, and
//            a credit-protected response FIFO per requester so no result is
//            ever dropped.
// Revision : 1.0 - initial release
// ============================================================================
module exp_share_arbiter #(
  parameter int NREQ      = 4,
  parameter int EXP_LAT   = 0,
  parameter int RSP_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [16*NREQ-1:0]   req_x,
  output logic [NREQ-1:0]      req_ready,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [16*NREQ-1:0]   rsp_y,
  input  logic [NREQ-1:0]      rsp_ready,
  output logic [15:0]          exp_x,
  input  logic [15:0]          exp_y,
  output logic                 busy
);

  localparam int TW   = $clog2(NREQ);
  localparam int AW   = $clog2(RSP_DEPTH);
  localparam int CW   = $clog2(RSP_DEPTH + 1);
  localparam int NSTG = EXP_LAT + 1;

  // Occupancy limit compared against FIFO count plus in-flight ops.
  localparam logic [CW:0]   DEPTH_W  = (CW+1)'(RSP_DEPTH);
  localparam logic [CW-1:0] CNT_FULL = CW'(RSP_DEPTH);

  // Arbitration
  logic [NREQ-1:0] elig_w;
  logic [NREQ-1:0] grant_w;
  logic            any_grant_w;
  logic [TW-1:0]   gidx_w;
  logic [15:0]     sel_x_w;
  logic [TW-1:0]   ptr_q;
  logic [TW-1:0]   ptr_d;

  // Issue register and tag pipeline
  logic [15:0]     exp_x_q;
  logic [NSTG-1:0] vld_q;
  logic [TW-1:0]   tag_q [NSTG];
  logic            cap_w;
  logic [TW-1:0]   cap_tag_w;

  // Round-robin scan from the pointer: first eligible requester wins.
  always_comb begin
    int idx;
    idx         = 0;
    grant_w     = '0;
    any_grant_w = 1'b0;
    gidx_w      = '0;
    sel_x_w     = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!any_grant_w && elig_w[idx]) begin
        any_grant_w  = 1'b1;
        grant_w[idx] = 1'b1;
        gidx_w       = idx[TW-1:0];
        sel_x_w      = req_x[16*idx +: 16];
      end
    end
  end

  // Pointer moves just past the winner; holds when nobody is granted.
  always_comb begin
    ptr_d = ptr_q;
    if (any_grant_w) begin
      ptr_d = (gidx_w == TW'(NREQ-1)) ? '0 : gidx_w + TW'(1);
    end
  end

  // Issue register, RR pointer and the (valid, tag) shift pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q   <= '0;
      exp_x_q <= '0;
      vld_q   <= '0;
      for (int s = 0; s < NSTG; s++) begin
        tag_q[s] <= '0;
      end
    end else begin
      ptr_q    <= ptr_d;
      vld_q[0] <= any_grant_w;
      tag_q[0] <= gidx_w;
      if (any_grant_w) begin
        exp_x_q <= sel_x_w;
      end
      for (int s = 1; s < NSTG; s++) begin
        vld_q[s] <= vld_q[s-1];
        tag_q[s] <= tag_q[s-1];
      end
    end
  end

  // exp_y lines up with the last pipeline stage.
  assign cap_w     = vld_q[NSTG-1];
  assign cap_tag_w = tag_q[NSTG-1];

  assign exp_x     = exp_x_q;
  assign req_ready = grant_w;
  assign busy      = (|vld_q) | (|rsp_valid);

  // Per-requester credit tracking and response FIFO.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [CW-1:0] infl_q;
    logic [CW-1:0] infl_d;
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [15:0]   mem_q [RSP_DEPTH];
    logic          push_w;
    logic          pop_w;
    logic [CW:0]   used_w;

    assign push_w = cap_w && (cap_tag_w == TW'(gi));
    assign pop_w  = rsp_valid[gi] && rsp_ready[gi];

    // Credit uses registered counts only, so a pop frees a slot next cycle.
    assign used_w      = {1'b0, cnt_q} + {1'b0, infl_q};
    assign elig_w[gi]  = rst_n && req_valid[gi] && (used_w < DEPTH_W);

    assign rsp_valid[gi]       = (cnt_q != '0);
    assign rsp_y[16*gi +: 16]  = mem_q[rd_ptr_q];

    // Next-state for FIFO occupancy and in-flight count.
    always_comb begin
      cnt_d = cnt_q;
      if (push_w && !pop_w) begin
        cnt_d = cnt_q + CW'(1);
      end else if (pop_w && !push_w) begin
        cnt_d = cnt_q - CW'(1);
      end
      infl_d = infl_q;
      if (grant_w[gi] && !push_w) begin
        infl_d = infl_q + CW'(1);
      end else if (push_w && !grant_w[gi]) begin
        infl_d = infl_q - CW'(1);
      end
    end

    // FIFO pointers and counters; reset discards everything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q    <= '0;
        infl_q   <= '0;
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        cnt_q  <= cnt_d;
        infl_q <= infl_d;
        if (push_w) wr_ptr_q <= wr_ptr_q + AW'(1);
        if (pop_w)  rd_ptr_q <= rd_ptr_q + AW'(1);
      end
    end

    // FIFO storage; contents are meaningless while the count is zero.
    always_ff @(posedge clk) begin
      if (push_w) begin
        mem_q[wr_ptr_q] <= exp_y;
      end
    end

`ifndef SYNTHESIS
    // Credit accounting must make an overflowing push unreachable.
    a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
      !(push_w && (cnt_q == CNT_FULL)));
`endif
  end

endmodule
`default_nettype wire

// File: tb/tb_exp_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_exp_share_arbiter
// Desc     : Bench for exp_share_arbiter. Two instances (EXP_LAT 0 and 3)
//            run in lockstep against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_exp_share_arbiter;

  localparam int NREQ  = 4;
  localparam int DEPTH = 2;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [NREQ-1:0]     req_valid = '0;
  logic [16*NREQ-1:0]  req_x = '0;
  logic [NREQ-1:0]     rsp_ready = '0;

  logic [NREQ-1:0]     rdy0, rdy1, rv0, rv1;
  logic [16*NREQ-1:0]  ry0, ry1;
  logic [15:0]         ex0, ex1, ey0, ey1;
  logic                bz0, bz1;
  logic [15:0]         lat_pipe [3];

  always #5 clk = ~clk;

  exp_share_arbiter #(.NREQ(NREQ), .EXP_LAT(0), .RSP_DEPTH(DEPTH)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_x(req_x),
    .req_ready(rdy0), .rsp_valid(rv0), .rsp_y(ry0), .rsp_ready(rsp_ready),
    .exp_x(ex0), .exp_y(ey0), .busy(bz0));

  exp_share_arbiter #(.NREQ(NREQ), .EXP_LAT(3), .RSP_DEPTH(DEPTH)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_x(req_x),
    .req_ready(rdy1), .rsp_valid(rv1), .rsp_y(ry1), .rsp_ready(rsp_ready),
    .exp_x(ex1), .exp_y(ey1), .busy(bz1));

  // Reference BF16 exp: real arithmetic, truncating, flush/saturate.
  function automatic logic [15:0] bf16_exp(input logic [15:0] x);
    logic [63:0] b;
    real         r;
    int          e;
    if (x[14:7] == 8'd0) r = 0.0;
    else begin
      b = {x[15], 11'(int'(x[14:7]) - 127 + 1023), x[6:0], 45'd0};
      r = $bitstoreal(b);
    end
    b = $realtobits($exp(r));
    e = int'(b[62:52]) - 1023 + 127;
    if (e >= 255) return 16'h7f80;
    if (e <= 0) return 16'h0000;
    return {1'b0, e[7:0], b[51:45]};
  endfunction

  // Exp units: combinational for instance 0, three register stages for 1.
  always_comb ey0 = bf16_exp(ex0);
  always @(posedge clk) begin
    lat_pipe[0] <= bf16_exp(ex1);
    lat_pipe[1] <= lat_pipe[0];
    lat_pipe[2] <= lat_pipe[1];
  end
  always_comb ey1 = lat_pipe[2];

  // ---------------- reference model ----------------
  typedef struct { int d; int tag; logic [15:0] y; int due; } op_t;
  op_t             pend [$];
  logic [15:0]     mq [2*NREQ][$];
  int              ptr_m [2];
  logic [15:0]     xlast [2];
  int              gidx [2];
  logic [15:0]     gxv [2];
  logic [NREQ-1:0] last_rdy [2];
  int              cyc = 0;
  int              tests = 0;
  int              fails = 0;

  function automatic int lat(input int d);
    return (d == 0) ? 0 : 3;
  endfunction
  function automatic logic [NREQ-1:0] get_rdy(input int d);
    return (d == 0) ? rdy0 : rdy1;
  endfunction
  function automatic logic [NREQ-1:0] get_rv(input int d);
    return (d == 0) ? rv0 : rv1;
  endfunction
  function automatic logic [16*NREQ-1:0] get_ry(input int d);
    return (d == 0) ? ry0 : ry1;
  endfunction
  function automatic logic [15:0] get_ex(input int d);
    return (d == 0) ? ex0 : ex1;
  endfunction
  function automatic logic get_bz(input int d);
    return (d == 0) ? bz0 : bz1;
  endfunction

  function automatic int inflight(input int d, input int i);
    int n = 0;
    foreach (pend[p]) if (pend[p].d == d && pend[p].tag == i) n++;
    return n;
  endfunction
  function automatic int pend_count(input int d);
    int n = 0;
    foreach (pend[p]) if (pend[p].d == d) n++;
    return n;
  endfunction

  function automatic logic [15:0] rnd_x();
    return {1'($urandom), 8'($urandom_range(8'h88, 8'h70)), 7'($urandom)};
  endfunction

  task automatic set_all_x();
    for (int i = 0; i < NREQ; i++) req_x[16*i +: 16] = rnd_x();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic model_clear();
    pend.delete();
    for (int q = 0; q < 2*NREQ; q++) mq[q].delete();
    for (int d = 0; d < 2; d++) begin
      ptr_m[d] = 0;
      xlast[d] = '0;
      gidx[d]  = -1;
    end
  endtask

  // One clock: compare at negedge, advance the model at posedge.
  task automatic tick();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      logic [NREQ-1:0] exp_rdy;
      logic [NREQ-1:0] exp_rv;
      logic [16*NREQ-1:0] ry;
      exp_rdy = '0;
      exp_rv  = '0;
      ry      = get_ry(d);
      gidx[d] = -1;
      for (int k = 0; k < NREQ; k++) begin
        int i;
        i = (ptr_m[d] + k) % NREQ;
        if (rst_n && gidx[d] < 0 && req_valid[i] &&
            (mq[d*NREQ+i].size() + inflight(d, i) < DEPTH)) gidx[d] = i;
      end
      if (gidx[d] >= 0) begin
        exp_rdy[gidx[d]] = 1'b1;
        gxv[d] = req_x[16*gidx[d] +: 16];
      end
      last_rdy[d] = get_rdy(d);
      chk($sformatf("d%0d_req_ready", d), 32'(get_rdy(d)), 32'(exp_rdy));
      for (int i = 0; i < NREQ; i++) begin
        exp_rv[i] = (mq[d*NREQ+i].size() > 0);
        if (exp_rv[i])
          chk($sformatf("d%0d_rsp_y%0d", d, i), 32'(ry[16*i +: 16]), 32'(mq[d*NREQ+i][0]));
      end
      chk($sformatf("d%0d_rsp_valid", d), 32'(get_rv(d)), 32'(exp_rv));
      chk($sformatf("d%0d_busy", d), 32'(get_bz(d)),
          32'((pend_count(d) > 0) || (exp_rv != '0)));
      chk($sformatf("d%0d_exp_x", d), 32'(get_ex(d)), 32'(xlast[d]));
    end
    @(posedge clk);
    if (!rst_n) model_clear();
    else begin
      op_t keep [$];
      for (int d = 0; d < 2; d++)
        for (int i = 0; i < NREQ; i++)
          if (mq[d*NREQ+i].size() > 0 && rsp_ready[i]) void'(mq[d*NREQ+i].pop_front());
      foreach (pend[p]) begin
        if (pend[p].due == cyc) mq[pend[p].d*NREQ + pend[p].tag].push_back(pend[p].y);
        else keep.push_back(pend[p]);
      end
      pend = keep;
      for (int d = 0; d < 2; d++) begin
        if (gidx[d] >= 0) begin
          pend.push_back('{d, gidx[d], bf16_exp(gxv[d]), cyc + 1 + lat(d)});
          ptr_m[d] = (gidx[d] + 1) % NREQ;
          xlast[d] = gxv[d];
        end
      end
    end
    cyc++;
    #1;
  endtask

  task automatic drain();
    req_valid = '0;
    rsp_ready = '1;
    repeat (12) tick();
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    logic [15:0] dir_x [3];
    logic [15:0] dir_y [3];
    logic [15:0] bval;
    int          g1 [2];
    dir_x[0] = 16'h0000; dir_y[0] = 16'h3f80;
    dir_x[1] = 16'h4300; dir_y[1] = 16'h7f80;
    dir_x[2] = 16'hC300; dir_y[2] = 16'h0000;
    model_clear();

    // Reset state
    req_valid = '1;
    set_all_x();
    repeat (3) tick();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_d%0d_req_ready", d), 32'(get_rdy(d)), 32'h0);
      chk($sformatf("rst_d%0d_exp_x", d), 32'(get_ex(d)), 32'h0);
      chk($sformatf("rst_d%0d_busy", d), 32'(get_bz(d)), 32'h0);
    end
    req_valid = '0;
    rst_n = 1'b1;
    tick();

    // Single operations on requester 0 with known exp values
    rsp_ready = '1;
    for (int n = 0; n < 3; n++) begin
      req_valid = 4'b0001;
      set_all_x();
      req_x[15:0] = dir_x[n];
      tick();
      chk("single_grant_d0", 32'(last_rdy[0]), 32'h1);
      chk("single_grant_d1", 32'(last_rdy[1]), 32'h1);
      req_valid = '0;
      chk("single_early_d0", 32'(rv0[0]), 32'h0);
      tick();
      chk("single_valid_d0", 32'(rv0[0]), 32'h1);
      chk("single_y_d0", 32'(ry0[15:0]), 32'(dir_y[n]));
      repeat (3) tick();
      chk("single_valid_d1", 32'(rv1[0]), 32'h1);
      chk("single_y_d1", 32'(ry1[15:0]), 32'(dir_y[n]));
      tick();
    end
    drain();

    // All requesters continuously valid, consumers always ready
    req_valid = '1;
    rsp_ready = '1;
    repeat (40) begin
      set_all_x();
      tick();
    end
    drain();

    // Backpressure on requester 1
    req_valid = '1;
    rsp_ready = 4'b1101;
    g1[0] = 0; g1[1] = 0;
    repeat (12) begin
      set_all_x();
      tick();
      for (int d = 0; d < 2; d++) g1[d] += int'(last_rdy[d][1]);
    end
    chk("bp_grants_d0", 32'(g1[0]), 32'd2);
    chk("bp_grants_d1", 32'(g1[1]), 32'd2);
    rsp_ready = 4'b1111;
    g1[0] = 0; g1[1] = 0;
    set_all_x();
    tick();
    chk("bp_same_cycle_d0", 32'(last_rdy[0][1]), 32'h0);
    chk("bp_same_cycle_d1", 32'(last_rdy[1][1]), 32'h0);
    rsp_ready = 4'b1101;
    repeat (10) begin
      set_all_x();
      tick();
      for (int d = 0; d < 2; d++) g1[d] += int'(last_rdy[d][1]);
    end
    chk("bp_release_d0", 32'(g1[0]), 32'd1);
    chk("bp_release_d1", 32'(g1[1]), 32'd1);
    drain();

    // Push and pop on the same edge with one entry held (lane 2)
    rsp_ready = 4'b1011;
    req_valid = 4'b0100;
    set_all_x();
    tick();
    req_valid = '0;
    tick();
    req_valid = 4'b0100;
    set_all_x();
    bval = req_x[47:32];
    tick();
    req_valid = '0;
    rsp_ready = 4'b1111;
    tick();
    rsp_ready = 4'b1011;
    chk("pushpop_valid_d0", 32'(rv0[2]), 32'h1);
    chk("pushpop_head_d0", 32'(ry0[47:32]), 32'(bf16_exp(bval)));
    repeat (3) tick();
    drain();

    // Randomised traffic
    repeat (300) begin
      req_valid = NREQ'($urandom);
      rsp_ready = NREQ'($urandom | $urandom);
      set_all_x();
      tick();
    end
    drain();

    // Reset mid-stream with full FIFOs and ops in flight
    req_valid = '1;
    rsp_ready = '0;
    repeat (12) begin
      set_all_x();
      tick();
    end
    rsp_ready = '1;
    tick();
    rsp_ready = '0;
    repeat (2) begin
      set_all_x();
      tick();
    end
    #2;
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("async_d%0d_rsp_valid", d), 32'(get_rv(d)), 32'h0);
      chk($sformatf("async_d%0d_busy", d), 32'(get_bz(d)), 32'h0);
      chk($sformatf("async_d%0d_req_ready", d), 32'(get_rdy(d)), 32'h0);
    end
    model_clear();
    repeat (2) tick();
    rst_n = 1'b1;
    rsp_ready = '1;
    set_all_x();
    tick();
    chk("post_rst_grant_d0", 32'(last_rdy[0]), 32'h1);
    chk("post_rst_grant_d1", 32'(last_rdy[1]), 32'h1);
    repeat (10) begin
      set_all_x();
      tick();
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/exp_share_arbiter.md
Name: exp_share_arbiter

Overview:
- Shares one BF16 exp approximation unit (combinational or pipelined, instantiated by the parent) among NREQ requesters.
- Round-robin arbitration with valid/ready handshakes.
- Tags each issued operand and tracks it through the unit's fixed latency.
- Returns each result through a per-requester response FIFO, with credit-based issue so no result is ever dropped.
- Sits between the softmax/activation lanes and the exp datapath.

Parameters:
NREQ, 4, number of requesters (2..8)
EXP_LAT, 0, register stages inside the exp unit between exp_x and exp_y (0 = combinational)
RSP_DEPTH, 2, entries per requester response FIFO (power of two, >=2)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NREQ  per-requester operand valid
req_x  in  16*NREQ  BF16 operands; requester i at bits [16i+15:16i]
req_ready  out  NREQ  operand accepted this cycle (one-hot or zero)
rsp_valid  out  NREQ  per-requester result valid (FIFO non-empty)
rsp_y  out  16*NREQ  BF16 results, FIFO head, same packing as req_x
rsp_ready  in  NREQ  requester consumes head
exp_x  out  16  operand to exp unit (registered)
exp_y  in  16  result from exp unit
busy  out  1  any operation in flight or any FIFO non-empty

Behaviour:
- Reset (async assert, sync release): all pipeline valids 0, FIFOs empty, RR pointer 0, exp_x=0x0000, rsp_valid=0, req_ready=0, busy=0. Reset mid-operation discards in-flight ops and FIFO contents; no response is produced for them.
- credit[i] = RSP_DEPTH - fifo_count[i] - inflight[i]. Requester i is eligible when req_valid[i] && credit[i]>0.
- Arbitration is combinational:
  - Grant the first eligible requester scanning from the RR pointer upward, wrapping modulo NREQ.
  - req_ready[i]=grant[i]; req_ready may depend on req_valid.
  - At most one grant per cycle.
  - After a grant to i, pointer <= (i+1) mod NREQ. With no grant, the pointer holds.
- Issue: on grant, the next edge loads exp_x<=req_x[i], stage0_valid<=1, stage0_tag<=i. With no grant, stage0_valid<=0 and exp_x holds its value.
- Tag pipeline: EXP_LAT further (valid, tag) stages shift every cycle. No stall; the unit is never back-pressured.
- Capture: exp_y is aligned with the last stage. When the last stage is valid, exp_y is pushed into FIFO[tag] on that edge.
- Latency, grant to rsp_valid: EXP_LAT+2 cycles (issue register, capture edge, FIFO output visible). With EXP_LAT=0, grant at cycle t gives rsp_valid at t+2.
- inflight[i] counts valid pipeline stages tagged i. It increments on grant to i and decrements on capture for i; both in the same cycle leave it unchanged.
- FIFO:
  - Pop when rsp_valid[i]&&rsp_ready[i].
  - Push and pop in the same cycle leave the count unchanged.
  - Push-when-full is impossible by credit; assert in simulation.
  - rsp_y shows the head; its value is don't-care when empty.
  - Pointers wrap modulo RSP_DEPTH.
- Credit updates from pops take effect in the next cycle's arbitration (registered counts only).
- Per-requester results return in issue order. Cross-requester ordering is not guaranteed to consumers.
- busy = OR of pipeline valids | OR of FIFO non-empty.

Test Plan:
- Single op, EXP_LAT=0, real exp unit: req0 x=0x0000 → rsp_valid[0] exactly 2 cycles after req_ready[0], y=0x3f80. x=0x4300 → 0x7f80. x=0xC300 → 0x0000.
- All 4 requesters valid continuously, rsp_ready=1: grants cycle 0,1,2,3,0,1,… one per cycle; each requester receives its own operands in order, with tags correctly routed (use distinct operands per lane).
- Backpressure, RSP_DEPTH=2: req1 valid always, rsp_ready[1]=0 → exactly 2 grants, then req_ready[1] stays 0. Other requesters are still granted every cycle. Raise rsp_ready[1] for 1 cycle → exactly one further grant to req1, no earlier than the next cycle.
- EXP_LAT=3 (bench delays the model by 3): 4 back-to-back ops from mixed requesters → each result arrives 5 cycles after its grant, in the correct FIFO; credit counts in-flight ops (req with DEPTH=2 and 2 in flight is not granted).
- Simultaneous push/pop on a FIFO holding 1 entry → count stays 1, head advances correctly, no lost or duplicated data.
- Assert rst_n low mid-stream with 3 ops in flight and full FIFOs → all rsp_valid=0 and busy=0 immediately (async). After release, the RR pointer is 0 and no stale responses appear.
